// File: rtl/sum_normalizer.sv
// Post-adder normalize/round/repack stage: signed sum + common exponent -> packed {sign, exp, sig}.
// Optional feature macro: SUM_NORM_RNE_EN (round-to-nearest-even; default build truncates).
module sum_normalizer #(
  parameter int expWidth   = 4,
  parameter int sigWidth   = 4,
  parameter int low_expand = 2,
  localparam int SUM_WIDTH = sigWidth + low_expand + 6,
  localparam int OUT_WIDTH = 1 + expWidth + sigWidth
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] sum,
  input  logic [expWidth-1:0]  max_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int HID = sigWidth + low_expand;
  localparam int PW  = $clog2(SUM_WIDTH);
  localparam int E_W = expWidth + 2;
`ifdef SUM_NORM_RNE_EN
  localparam int NORM_W = SUM_WIDTH - 1;
`else
  localparam int NORM_W = sigWidth;
`endif
  localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << expWidth) - 1);
  localparam logic signed [E_W-1:0] E_HID = E_W'(HID);

  // Handshake: input transfers on in_valid & in_ready, output on out_valid & out_ready;
  // a stalled output (out_valid & ~out_ready) freezes every stage and drops in_ready.
  logic stall;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q,  s1_sign_d;
  logic [SUM_WIDTH-1:0]   s1_mag_q,   s1_mag_d;
  logic [expWidth-1:0]    s1_exp_q,   s1_exp_d;

  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_sign_q,  s2_sign_d;
  logic                   s2_zero_q,  s2_zero_d;
  logic [NORM_W-1:0]      s2_norm_q,  s2_norm_d;
  logic signed [E_W-1:0]  s2_e_q,     s2_e_d;

  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q,  out_data_d;

  logic [PW-1:0]          lead_pos;
  logic [PW-1:0]          shamt;
  logic [SUM_WIDTH-1:0]   shifted;
  logic [sigWidth-1:0]    frac;
  logic [sigWidth-1:0]    frac_r;
  logic signed [E_W-1:0]  e_r;
`ifdef SUM_NORM_RNE_EN
  logic                   rnd_bit;
  logic                   sticky;
  logic                   inc;
  logic                   carry;
`endif

  // Stage 1: sign/magnitude split
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    in_ready = ~stall;
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_exp_d   = s1_exp_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s1_sign_d  = sum[SUM_WIDTH-1];
      s1_mag_d   = sum[SUM_WIDTH-1] ? (~sum + SUM_WIDTH'(1)) : sum;
      s1_exp_d   = max_exp;
    end
  end

  // Stage 2: leading-one detect, left-normalize, exponent adjust
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SUM_WIDTH; i++) begin
      if (s1_mag_q[i]) lead_pos = PW'(i);
    end
    shamt   = PW'(SUM_WIDTH - 1) - lead_pos;
    shifted = s1_mag_q << shamt;
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_norm_d  = s2_norm_q;
    s2_e_d     = s2_e_q;
    if (!stall) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = (s1_mag_q == '0);
      // Hidden one at the MSB is implicit, so only the bits below it are kept.
      s2_norm_d  = NORM_W'(shifted >> (SUM_WIDTH - 1 - NORM_W));
      s2_e_d     = $signed(E_W'(s1_exp_q)) + $signed(E_W'(lead_pos)) - E_HID;
    end
  end

  // Stage 3: round, range check, repack
  always_comb begin
    frac = s2_norm_q[NORM_W-1 -: sigWidth];
`ifdef SUM_NORM_RNE_EN
    rnd_bit = s2_norm_q[NORM_W-1-sigWidth];
    sticky  = |s2_norm_q[NORM_W-2-sigWidth:0];
    inc     = rnd_bit & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + (sigWidth + 1)'(inc);
    e_r     = s2_e_q + $signed(E_W'(carry));
`else
    frac_r  = frac;
    e_r     = s2_e_q;
`endif
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!stall) begin
      out_valid_d = s2_valid_q;
      out_data_d  = '0;
      if (s2_valid_q && !s2_zero_q && (e_r > 0)) begin
        if (e_r > E_MAX) out_data_d = {s2_sign_q, {(expWidth + sigWidth){1'b1}}};
        else             out_data_d = {s2_sign_q, e_r[expWidth-1:0], frac_r};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_exp_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_norm_q   <= '0;
      s2_e_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_exp_q    <= s1_exp_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_norm_q   <= s2_norm_d;
      s2_e_q      <= s2_e_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sum_normalizer.sv
// Directed bench for sum_normalizer (4/4/2): latency, rounding, range limits, backpressure, reset flush.
module tb_sum_normalizer;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] sum;
  logic [3:0]  max_exp;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic       held_valid = 1'b0;
  logic [8:0] held_data  = '0;

`ifdef SUM_NORM_RNE_EN
  localparam logic [8:0] EXP_67    = 9'h071;
  localparam logic [8:0] EXP_126   = 9'h080;
  localparam logic [8:0] EXP_2047  = 9'h090;
  localparam logic [8:0] EXP_126_E = 9'h0F0;
`else
  localparam logic [8:0] EXP_67    = 9'h070;
  localparam logic [8:0] EXP_126   = 9'h07F;
  localparam logic [8:0] EXP_2047  = 9'h08F;
  localparam logic [8:0] EXP_126_E = 9'h0EF;
`endif

  localparam int NV = 16;
  int         v_sum[NV] = '{64, -64, 128, 0, 16, 128, -128, 66, 67, 126, 96, 40, -3, 2047, 64, 128};
  int         v_exp[NV] = '{7,   7,   7,  9,  1,  15,   15,  7,  7,   7,  5,  9, 10,    4,  0,  14};
  logic [8:0] v_res[NV];

  sum_normalizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .max_exp   (max_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: present one input, push its expected result once accepted
  task automatic send(input int s, input int me, input logic [8:0] ev);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    sum      = 12'(s);
    max_exp  = 4'(me);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ev);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: in-order compare of delivered results, hold check while stalled
  always @(negedge clk) begin
    if (!rstn) begin
      held_valid = 1'b0;
    end else if (out_valid) begin
      if (held_valid) check("hold_data", 32'(out_data), 32'(held_data));
      if (out_ready) begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end else begin
        held_valid = 1'b1;
        held_data  = out_data;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    v_res = '{9'h070, 9'h170, 9'h080, 9'h000, 9'h000, 9'h0FF, 9'h1FF, 9'h070,
              EXP_67, EXP_126, 9'h058, 9'h084, 9'h158, EXP_2047, 9'h000, 9'h0F0};
    rstn      = 1'b0;
    in_valid  = 1'b0;
    sum       = '0;
    max_exp   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    idle(2);

    // Latency: valid appears after the third rising edge counting the accepting one
    send(64, 7, 9'h070);
    check("lat_edge1", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_edge2", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_edge3", 32'(out_valid), 32'd1);
    idle(3);

    // Directed table streamed back to back
    for (int i = 0; i < NV; i++) send(v_sum[i], v_exp[i], v_res[i]);
    send(126, 14, EXP_126_E);
    send(-126, 15, 9'h1FF);
    send(64, 1, 9'h010);
    idle(6);
    check("drain_table", 32'(exp_q.size()), 32'd0);

    // Eight back-to-back inputs with out_ready low for three cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send(v_sum[i], v_exp[i], v_res[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("drain_bp", 32'(exp_q.size()), 32'd0);

    // Reset with three results in flight: nothing may emerge afterwards
    send(128, 7, 9'h080);
    send(-64, 7, 9'h170);
    send(96, 5, 9'h058);
    rstn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", 32'(out_data), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    idle(6);
    check("flush_quiet", 32'(out_valid), 32'd0);

    // Pipeline still works after the flush
    send(-3, 10, 9'h158);
    idle(5);
    check("drain_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
